// File: rtl/unigate_cfg_ctrl.sv
// unigate_cfg_ctrl: shifts a CHAIN_LEN-bit configuration frame into unigate, fed by Wishbone or the LA.
// Define UNIGATE_CFG_IRQ_EN to build the done-level interrupt on irq_o.
//
// state    | meaning
// IDLE     | no frame; arbitrate WB / LA requests
// FETCH    | wait for the next 32-bit word from the owner
// SHIFT_LO | cfg_clk_o low, current bit on cfg_data_o
// SHIFT_HI | cfg_clk_o high, unigate samples the bit
// LATCH    | one-cycle cfg_latch_o pulse, frame done
module unigate_cfg_ctrl #(
  parameter int CHAIN_LEN  = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        la_req_i,
  input  logic        la_valid_i,
  input  logic [31:0] la_data_i,
  output logic        la_ready_o,
  output logic        cfg_clk_o,
  output logic        cfg_data_o,
  output logic        cfg_latch_o,
  output logic        busy_o,
  output logic        irq_o
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int WORDS = CHAIN_LEN / 32;
  localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT_LO, SHIFT_HI, LATCH} state_e;

  state_e          state_q;
  logic            ack_q, ovf_q, la_en_q, done_q, owner_la_q, last_wb_q, wb_pend_q;
  logic            busy_q, la_ready_q, cfg_clk_q, cfg_data_q, cfg_latch_q;
  logic [31:0]     dat_q, sh_q;
  logic [4:0]      bit_cnt_q;
  logic [WCW-1:0]  word_cnt_q;
  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [PW:0]     wr_ptr_q, rd_ptr_q, lvl;
  logic            irq_present;
  logic            unused_ok;

  assign unused_ok = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0]};

`ifdef UNIGATE_CFG_IRQ_EN
  assign irq_present = 1'b1;
  assign irq_o       = done_q;
`else
  assign irq_present = 1'b0;
  assign irq_o       = 1'b0;
`endif

  logic wb_req, wr, wdata_wr, ctrl_wr, abort_wr, start_wr;
  assign wb_req   = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr       = wb_req & wbs_we_i;
  assign wdata_wr = wr & (wbs_adr_i[3:2] == 2'd0);
  assign ctrl_wr  = wr & (wbs_adr_i[3:2] == 2'd1);
  assign abort_wr = ctrl_wr & wbs_dat_i[1];
  assign start_wr = ctrl_wr & wbs_dat_i[0] & ~wbs_dat_i[1] & (state_q == IDLE);

  logic full, empty, push, pop;
  assign lvl   = wr_ptr_q - rd_ptr_q;
  assign full  = (lvl == (PW+1)'(FIFO_DEPTH));
  assign empty = (lvl == '0);
  assign push  = wdata_wr & ~full;
  assign pop   = (state_q == FETCH) & ~owner_la_q & ~empty & ~abort_wr;

  // A losing WB start is remembered in wb_pend_q; the LA request is a level and needs no memory.
  logic la_want, wb_want, grant_wb, grant_la, take;
  logic [31:0] fetch_word, rdata;
  assign la_want    = la_req_i & la_en_q;
  assign wb_want    = start_wr | wb_pend_q;
  assign grant_wb   = wb_want & (~la_want | ~last_wb_q);
  assign grant_la   = la_want & (~wb_want | last_wb_q);
  assign fetch_word = owner_la_q ? la_data_i : mem_q[rd_ptr_q[PW-1:0]];
  assign take       = owner_la_q ? (la_ready_q & la_valid_i) : ~empty;
  assign rdata      = (wbs_adr_i[3:2] == 2'd2) ?
                      {24'd0, 4'(lvl), irq_present, owner_la_q, ovf_q, done_q} : 32'd0;

  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= wbs_dat_i;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (abort_wr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      ovf_q   <= 1'b0;
      la_en_q <= 1'b0;
    end else begin
      ack_q <= wb_req;
      if (wb_req) dat_q <= wbs_we_i ? 32'd0 : rdata;
      if (start_wr) ovf_q <= 1'b0;
      else if (wdata_wr && full) ovf_q <= 1'b1;
      if (ctrl_wr) la_en_q <= wbs_dat_i[2];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      la_ready_q  <= 1'b0;
      cfg_clk_q   <= 1'b0;
      cfg_data_q  <= 1'b0;
      cfg_latch_q <= 1'b0;
      done_q      <= 1'b0;
      owner_la_q  <= 1'b0;
      last_wb_q   <= 1'b0;
      wb_pend_q   <= 1'b0;
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
    end else begin
      cfg_clk_q   <= 1'b0;
      cfg_latch_q <= 1'b0;
      if (start_wr) done_q <= 1'b0;
      if (abort_wr) begin
        state_q    <= IDLE;
        busy_q     <= 1'b0;
        la_ready_q <= 1'b0;
        wb_pend_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (grant_wb || grant_la) begin
            state_q    <= FETCH;
            busy_q     <= 1'b1;
            owner_la_q <= grant_la;
            last_wb_q  <= grant_wb;
            la_ready_q <= grant_la;
            wb_pend_q  <= wb_want & ~grant_wb;
            word_cnt_q <= WCW'(WORDS - 1);
          end
          FETCH: if (take) begin
            state_q    <= SHIFT_LO;
            la_ready_q <= 1'b0;
            cfg_data_q <= fetch_word[0];
            sh_q       <= {1'b0, fetch_word[31:1]};
            bit_cnt_q  <= 5'd31;
          end
          SHIFT_LO: begin
            state_q   <= SHIFT_HI;
            cfg_clk_q <= 1'b1;
          end
          SHIFT_HI: if (bit_cnt_q == 5'd0) begin
            if (word_cnt_q == '0) begin
              state_q     <= LATCH;
              cfg_latch_q <= 1'b1;
            end else begin
              state_q    <= FETCH;
              word_cnt_q <= word_cnt_q - 1'b1;
              la_ready_q <= owner_la_q;
            end
          end else begin
            state_q    <= SHIFT_LO;
            bit_cnt_q  <= bit_cnt_q - 5'd1;
            cfg_data_q <= sh_q[0];
            sh_q       <= {1'b0, sh_q[31:1]};
          end
          LATCH: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign la_ready_o  = la_ready_q;
  assign cfg_clk_o   = cfg_clk_q;
  assign cfg_data_o  = cfg_data_q;
  assign cfg_latch_o = cfg_latch_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_unigate_cfg_ctrl.sv
// Self-checking bench for unigate_cfg_ctrl with a 64-bit chain; shifted bits are scoreboarded.
module tb_unigate_cfg_ctrl;

`ifdef UNIGATE_CFG_IRQ_EN
  localparam bit IRQP = 1'b1;
`else
  localparam bit IRQP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wbs_cyc_i = 0, wbs_stb_i = 0, wbs_we_i = 0;
  logic [31:0] wbs_adr_i = 0, wbs_dat_i = 0;
  logic [3:0]  wbs_sel_i = 0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        la_req_i = 0, la_valid_i = 0;
  logic [31:0] la_data_i = 0;
  logic        la_ready_o, cfg_clk_o, cfg_data_o, cfg_latch_o, busy_o, irq_o;

  unigate_cfg_ctrl #(.CHAIN_LEN(64), .FIFO_DEPTH(4)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .la_req_i(la_req_i), .la_valid_i(la_valid_i), .la_data_i(la_data_i), .la_ready_o(la_ready_o),
    .cfg_clk_o(cfg_clk_o), .cfg_data_o(cfg_data_o), .cfg_latch_o(cfg_latch_o),
    .busy_o(busy_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rise_cnt = 0;
  int latch_cnt = 0;
  logic prev_clk = 1'b0;
  logic exp_bits[$];
  logic [31:0] exp_rd[$];
  bit m_done, m_ovf, m_owner;
  int m_lvl;

  function automatic logic [31:0] status_exp();
    logic [3:0] l;
    l = 4'(m_lvl);
    return {24'd0, l, IRQP, m_owner, m_ovf, m_done};
  endfunction

  // Bit scoreboard: every rising cfg_clk_o consumes one expected bit.
  always @(negedge clk) begin
    if (!rst_n) prev_clk = 1'b0;
    else begin
      if (cfg_clk_o && !prev_clk) begin
        logic e;
        rise_cnt++;
        checks++;
        if (exp_bits.size() == 0) begin
          errors++;
          $display("FAIL cfg_bit: unexpected shift, cfg_data_o=%b required none", cfg_data_o);
        end else begin
          e = exp_bits.pop_front();
          if (cfg_data_o !== e) begin
            errors++;
            $display("FAIL cfg_bit %0d: cfg_data_o=%b required %b", rise_cnt, cfg_data_o, e);
          end
        end
      end
      if (cfg_latch_o) latch_cnt++;
      prev_clk = cfg_clk_o;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wb_cycle(input logic we, input logic [1:0] a, input logic [31:0] d,
                          output bit acked, output logic [31:0] rd);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we;
    wbs_adr_i = {28'd0, a, 2'b00}; wbs_dat_i = d; wbs_sel_i = 4'($urandom);
    acked = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (wbs_ack_o) begin acked = 1; break; end
    end
    rd = wbs_dat_o;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    if (!acked) begin
      errors++;
      $display("FAIL wb_ack_timeout: wbs_ack_o=0 required 1 (adr %0d)", a);
    end
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    bit ak; logic [31:0] rd;
    wb_cycle(1'b1, a, d, ak, rd);
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] rd);
    bit ak;
    wb_cycle(1'b0, a, 32'd0, ak, rd);
  endtask

  task automatic wb_push_word(input logic [31:0] d);
    wb_write(2'd0, d);
    for (int i = 0; i < 32; i++) exp_bits.push_back(d[i]);
  endtask

  task automatic la_send(input logic [31:0] d);
    int n = 0;
    while (la_ready_o !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    if (la_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL la_ready_timeout: la_ready_o=%b required 1", la_ready_o);
    end else begin
      for (int i = 0; i < 32; i++) exp_bits.push_back(d[i]);
      la_data_i = d; la_valid_i = 1;
      @(posedge clk); #1;
      la_valid_i = 0;
    end
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (busy_o && n < maxc) begin @(posedge clk); #1; n++; end
    if (busy_o) begin
      errors++;
      $display("FAIL frame_timeout: busy_o=1 required 0");
    end
  endtask

  task automatic wait_cond_rises(input int target, input int maxc);
    int n = 0;
    while (rise_cnt < target && n < maxc) begin @(posedge clk); #1; n++; end
    if (rise_cnt < target) begin
      errors++;
      $display("FAIL shift_timeout: rises=%0d required %0d", rise_cnt, target);
    end
  endtask

  task automatic reset_dut();
    rst_n = 0;
    idle(2);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    m_done = 0; m_ovf = 0; m_owner = 0; m_lvl = 0;
    exp_bits.delete(); rise_cnt = 0; latch_cnt = 0;
  endtask

  task automatic test_reset();
    logic [31:0] rd, ex;
    rst_n = 0;
    idle(2);
    checks++;
    if ({wbs_ack_o, wbs_dat_o, la_ready_o, cfg_clk_o, cfg_data_o, cfg_latch_o, busy_o, irq_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b dat=%h rdy=%b clk=%b data=%b latch=%b busy=%b irq=%b required all 0",
               wbs_ack_o, wbs_dat_o, la_ready_o, cfg_clk_o, cfg_data_o, cfg_latch_o, busy_o, irq_o);
    end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    m_done = 0; m_ovf = 0; m_owner = 0; m_lvl = 0;
    exp_rd.push_back(status_exp());
    wb_read(2'd2, rd); ex = exp_rd.pop_front();
    checks++;
    if (rd !== ex) begin errors++; $display("FAIL status_reset: got %h required %h", rd, ex); end
    wb_write(2'd3, 32'hFFFF_FFFF);
    exp_rd.push_back(32'd0);
    wb_read(2'd3, rd); ex = exp_rd.pop_front();
    checks++;
    if (rd !== ex) begin errors++; $display("FAIL reg3_read: got %h required %h", rd, ex); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ex;
    bit exp_ack;
    idle(1);
    ex = status_exp();
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h8;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      exp_ack = ((i % 2) == 0);
      checks++;
      if (wbs_ack_o !== exp_ack || (exp_ack && wbs_dat_o !== ex)) begin
        errors++;
        $display("FAIL held_strobe cycle %0d: ack=%b dat=%h required ack=%b dat=%h", i, wbs_ack_o, wbs_dat_o, exp_ack, ex);
      end
    end
    wbs_cyc_i = 0; wbs_stb_i = 0;
    idle(2);
  endtask

  task automatic test_basic_frame();
    logic [31:0] rd, ex;
    wb_push_word(32'h0000_0001);
    wb_push_word(32'h8000_0000);
    rise_cnt = 0; latch_cnt = 0;
    wb_write(2'd1, 32'h1);
    m_done = 0; m_ovf = 0; m_owner = 0;
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b required 1", busy_o); end
    wait_cond_rises(10, 200);
    wb_write(2'd1, 32'h1);
    wait_idle(400);
    m_done = 1; m_lvl = 0;
    checks++;
    if (rise_cnt != 64 || latch_cnt != 1 || exp_bits.size() != 0 || cfg_clk_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_frame: rises=%0d latches=%0d left=%0d clk=%b required 64 1 0 0",
               rise_cnt, latch_cnt, exp_bits.size(), cfg_clk_o);
    end
    exp_rd.push_back(status_exp());
    wb_read(2'd2, rd); ex = exp_rd.pop_front();
    checks++;
    if (rd !== ex || irq_o !== (IRQP & m_done)) begin
      errors++;
      $display("FAIL status_done: got %h irq=%b required %h irq=%b", rd, irq_o, ex, IRQP & m_done);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] rd, ex;
    int acks = 0;
    bit ak;
    for (int i = 0; i < 5; i++) begin
      wb_cycle(1'b1, 2'd0, 32'(i + 1), ak, rd);
      if (ak) acks++;
    end
    m_ovf = 1; m_lvl = 4;
    checks++;
    if (acks != 5) begin errors++; $display("FAIL ovf_acks: got %0d required 5", acks); end
    exp_rd.push_back(status_exp());
    wb_read(2'd2, rd); ex = exp_rd.pop_front();
    checks++;
    if (rd !== ex) begin errors++; $display("FAIL status_ovf: got %h required %h", rd, ex); end
    wb_write(2'd1, 32'h2);
    m_lvl = 0;
    exp_rd.push_back(status_exp());
    wb_read(2'd2, rd); ex = exp_rd.pop_front();
    checks++;
    if (rd !== ex) begin errors++; $display("FAIL status_flush: got %h required %h", rd, ex); end
  endtask

  task automatic test_arbitration();
    logic [31:0] rd, ex;
    reset_dut();
    wb_push_word(32'hA5A5_0F0F);
    wb_push_word(32'h1234_5678);
    wb_write(2'd1, 32'h4);
    idle(1);
    la_req_i = 1;
    wb_write(2'd1, 32'h5);
    la_req_i = 0;
    m_done = 0; m_owner = 0;
    wait_idle(400);
    m_done = 1;
    checks++;
    if (rise_cnt != 64 || latch_cnt != 1 || exp_bits.size() != 0) begin
      errors++;
      $display("FAIL wb_first_frame: rises=%0d latches=%0d left=%0d required 64 1 0", rise_cnt, latch_cnt, exp_bits.size());
    end
    exp_rd.push_back(status_exp());
    wb_read(2'd2, rd); ex = exp_rd.pop_front();
    checks++;
    if (rd !== ex) begin errors++; $display("FAIL owner_wb_first: got %h required %h", rd, ex); end
    rise_cnt = 0; latch_cnt = 0;
    idle(1);
    la_req_i = 1;
    wb_write(2'd1, 32'h5);
    la_req_i = 0;
    m_done = 0; m_owner = 1;
    exp_rd.push_back(status_exp());
    wb_read(2'd2, rd); ex = exp_rd.pop_front();
    checks++;
    if (rd !== ex || irq_o !== 1'b0) begin
      errors++;
      $display("FAIL owner_la_second: got %h irq=%b required %h irq=0", rd, irq_o, ex);
    end
  endtask

  task automatic test_la_stall();
    int n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (la_ready_o !== 1'b1 || cfg_clk_o !== 1'b0) begin
        errors++;
        $display("FAIL la_stall cycle %0d: la_ready_o=%b cfg_clk_o=%b required 1 0", i, la_ready_o, cfg_clk_o);
      end
    end
    la_send(32'hDEAD_BEEF);
    la_send(32'h0000_FFFF);
    while (latch_cnt < 1 && n < 400) begin @(posedge clk); #1; n++; end
    m_done = 1;
    checks++;
    if (rise_cnt != 64 || latch_cnt != 1 || exp_bits.size() != 0) begin
      errors++;
      $display("FAIL la_frame: rises=%0d latches=%0d left=%0d required 64 1 0", rise_cnt, latch_cnt, exp_bits.size());
    end
  endtask

  task automatic test_abort_midshift();
    logic [31:0] rd, ex;
    int latch0;
    idle(3);
    m_owner = 0;
    checks++;
    if (busy_o !== 1'b1 || cfg_clk_o !== 1'b0) begin
      errors++;
      $display("FAIL pending_wb_stall: busy_o=%b cfg_clk_o=%b required 1 0", busy_o, cfg_clk_o);
    end
    rise_cnt = 0; latch0 = latch_cnt;
    wb_push_word(32'h0F0F_3C3C);
    wb_push_word(32'hFFFF_FFFF);
    wait_cond_rises(5, 200);
    wb_write(2'd1, 32'h2);
    checks++;
    if (busy_o !== 1'b0 || la_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: busy_o=%b la_ready_o=%b required 0 0", busy_o, la_ready_o);
    end
    exp_bits.delete();
    m_lvl = 0;
    idle(5);
    checks++;
    if (latch_cnt != latch0 || cfg_clk_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_latch: latches=%0d clk=%b required %0d 0", latch_cnt, cfg_clk_o, latch0);
    end
    exp_rd.push_back(status_exp());
    wb_read(2'd2, rd); ex = exp_rd.pop_front();
    checks++;
    if (rd !== ex || irq_o !== (IRQP & m_done)) begin
      errors++;
      $display("FAIL status_abort: got %h irq=%b required %h irq=%b", rd, irq_o, ex, IRQP & m_done);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rd, ex;
    int latch0;
    rise_cnt = 0;
    wb_push_word(32'h1357_9BDF);
    wb_push_word(32'h2468_ACE0);
    wb_write(2'd1, 32'h1);
    m_done = 0;
    wait_cond_rises(20, 200);
    latch0 = latch_cnt;
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    checks++;
    if ({wbs_ack_o, wbs_dat_o, la_ready_o, cfg_clk_o, cfg_data_o, cfg_latch_o, busy_o, irq_o} !== '0) begin
      errors++;
      $display("FAIL async_reset: ack=%b dat=%h rdy=%b clk=%b data=%b latch=%b busy=%b irq=%b required all 0",
               wbs_ack_o, wbs_dat_o, la_ready_o, cfg_clk_o, cfg_data_o, cfg_latch_o, busy_o, irq_o);
    end
    exp_bits.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    m_done = 0; m_ovf = 0; m_owner = 0; m_lvl = 0;
    idle(3);
    checks++;
    if (latch_cnt != latch0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_latch: latches=%0d busy=%b required %0d 0", latch_cnt, busy_o, latch0);
    end
    exp_rd.push_back(status_exp());
    wb_read(2'd2, rd); ex = exp_rd.pop_front();
    checks++;
    if (rd !== ex) begin errors++; $display("FAIL status_after_reset: got %h required %h", rd, ex); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_basic_frame();
    test_overflow();
    test_arbitration();
    test_la_stall();
    test_abort_midshift();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
